store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, store data width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 4, number of queue entries; a power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 16, width of the byte address.
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1, store request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted this cycle when high together with req_valid.
REQ-008 SHALL have port req_op, input, 2, store size: 0 none, 1 word (dword when DATA_W=64), 2 half, 3 byte.
REQ-009 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-010 SHALL have port req_data, input, DATA_W, unshifted store data.
REQ-011 SHALL have port req_ov, input, 1, address-calculation overflow flag.
REQ-012 SHALL have port exc_ades, output, 1, registered store address-error pulse.
REQ-013 SHALL have port exc_addr, output, ADDR_W, faulting address; valid while exc_ades is high.
REQ-014 SHALL have port mem_valid, output, 1, head entry presented to memory.
REQ-015 SHALL have port mem_ready, input, 1, memory accepts the head entry.
REQ-016 SHALL have port mem_addr, output, ADDR_W, lane-aligned address of the head entry (low log2(DATA_W/8) bits zero).
REQ-017 SHALL have port mem_we, output, DATA_W/8, per-byte write enables of the head entry.
REQ-018 SHALL have port mem_wdata, output, DATA_W, lane-shifted data of the head entry.
REQ-019 SHALL have port empty, output, 1, queue holds no entries.

Function
REQ-020 SHALL drive req_ready = !full; there is no same-cycle pass-through when full.
REQ-021 SHALL treat op 0 as a no-op: consume it, enqueue nothing, raise no exception.
REQ-022 SHALL set byte enables for full width (all lanes), half (the 2-byte lane selected by addr bits), or byte (the 1 lane selected by addr); data SHALL be replicated into the selected lane and other lanes zeroed.
REQ-023 SHALL flag misalignment: full-width store with any low offset bit set; half store with addr[0] set.
REQ-024 SHALL flag a range error unless the address lies in DM 0x0000-0x2FFF, TIMER0 0x7F00-0x7F0B, TIMER1 0x7F10-0x7F1B, or IRQGEN 0x7F20-0x7F23.
REQ-025 SHALL flag writes to timer COUNT registers (0x7F08-0x7F0B, 0x7F18-0x7F1B) and any non-word store at or above 0x7F00.
REQ-026 SHALL treat any flagged accepted request (including req_ov=1) as a fault: not enqueued; exc_ades=1 and exc_addr=req_addr exactly one cycle later, for one cycle.
REQ-027 SHALL enqueue a clean accepted request at the tail; latency from acceptance to mem_valid SHALL be 1 cycle when the queue is empty.
REQ-028 SHALL drive mem_valid = !empty and pop the head on mem_valid && mem_ready; the head SHALL be stable while mem_valid && !mem_ready.
REQ-029 SHALL allow enqueue and dequeue in the same cycle; occupancy is then unchanged; pointers wrap modulo DEPTH.
REQ-030 SHALL deliver entries to memory in strict acceptance order.

Reset
REQ-031 SHALL, while reset_n=0, clear pointers and occupancy and force empty=1, req_ready=1, mem_valid=0, exc_ades=0, exc_addr=0; mem_addr/mem_we/mem_wdata SHALL read 0.
REQ-032 SHALL discard all queued stores and any pending exception when reset asserts mid-operation.

Configuration
REQ-033 SHALL, with STORE_MERGE_EN defined, merge a clean request into the tail entry instead of allocating, when the tail has the same lane-aligned address and is not being popped this cycle; merged bytes SHALL overwrite, and enables SHALL be ORed.
REQ-034 SHALL, with STORE_MERGE_EN defined, accept a merge even when full; without the macro, no merging occurs and every clean store allocates an entry.

Structure
REQ-035 SHALL take op encodings, address-range bounds, and the COUNT register offsets from a shared package store_pkg.
REQ-036 SHALL place the combinational lane/enable/exception check in one sub-module, store_check; the queue and handshake stay in store_buffer.

Verification
REQ-037 SHALL test: sb addr 0x0003 data 0x000000AB, DATA_W=32 -> mem_we 4'b1000, mem_wdata 0xAB000000, mem_addr 0x0000 one cycle later.
REQ-038 SHALL test: sw 0x0002, and sw 0x7F08 -> no mem_valid, exc_ades pulse next cycle with exc_addr 0x0002, then 0x7F08.
REQ-039 SHALL test: DEPTH=4 with mem_ready=0 and 5 distinct sw -> req_ready low after 4; release mem_ready -> 4 writes in order, then the 5th.
REQ-040 SHALL test: with STORE_MERGE_EN, mem_ready=0, sb 0x0010 = 0x11 then sb 0x0011 = 0x22 -> one entry, mem_we 4'b0011, mem_wdata 0x00002211.
REQ-041 SHALL test: reset_n low with 3 entries queued -> empty=1 and mem_valid=0 immediately; no write issued after release.

Source files
------------

// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared store op encodings, address map bounds and COUNT register offsets
package store_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_FULL = 2'd1,
        OP_HALF = 2'd2,
        OP_BYTE = 2'd3
    } store_op_e;

    localparam logic [31:0] DM_LO     = 32'h0000_0000;
    localparam logic [31:0] DM_HI     = 32'h0000_2FFF;
    localparam logic [31:0] TMR0_LO   = 32'h0000_7F00;
    localparam logic [31:0] TMR0_HI   = 32'h0000_7F0B;
    localparam logic [31:0] TMR1_LO   = 32'h0000_7F10;
    localparam logic [31:0] TMR1_HI   = 32'h0000_7F1B;
    localparam logic [31:0] IRQ_LO    = 32'h0000_7F20;
    localparam logic [31:0] IRQ_HI    = 32'h0000_7F23;
    localparam logic [31:0] MMIO_BASE = 32'h0000_7F00;

    // COUNT is read-only and sits at this byte offset inside each timer block
    localparam logic [31:0] COUNT_OFS = 32'h0000_0008;
    localparam logic [31:0] COUNT_LEN = 32'h0000_0004;

    function automatic logic in_win(input logic [31:0] a, input logic [31:0] lo,
                                    input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/store_check.sv
// rtl/store_check.sv - combinational lane placement, byte enables and store address checks
module store_check
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic [1:0]          op,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    input  logic                ov,
    output logic [DATA_W/8-1:0] we,
    output logic [DATA_W-1:0]   wdata,
    output logic                fault,
    output logic                clean
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);

    logic [LB-1:0]     off;
    logic [DATA_W-1:0] rep;
    logic              misalign;
    logic              in_map;
    logic              count_hit;
    logic              mmio_narrow;
    logic              flag;
    logic [31:0]       a32;

    always_comb begin
        off      = addr[LB-1:0];
        a32      = 32'(addr);
        we       = '0;
        rep      = '0;
        misalign = 1'b0;
        case (store_op_e'(op))
            OP_FULL: begin
                we       = '1;
                rep      = data;
                misalign = |off;
            end
            OP_HALF: begin
                we       = NB'(2'b11) << {off[LB-1:1], 1'b0};
                rep      = {(NB/2){data[15:0]}};
                misalign = off[0];
            end
            OP_BYTE: begin
                we  = NB'(1) << off;
                rep = {NB{data[7:0]}};
            end
            default: ;
        endcase
        for (int i = 0; i < NB; i++) begin
            wdata[8*i +: 8] = we[i] ? rep[8*i +: 8] : 8'h00;
        end

        in_map = in_win(a32, DM_LO, DM_HI) | in_win(a32, TMR0_LO, TMR0_HI)
               | in_win(a32, TMR1_LO, TMR1_HI) | in_win(a32, IRQ_LO, IRQ_HI);
        count_hit = in_win(a32, TMR0_LO + COUNT_OFS, TMR0_LO + COUNT_OFS + COUNT_LEN - 32'd1)
                  | in_win(a32, TMR1_LO + COUNT_OFS, TMR1_LO + COUNT_OFS + COUNT_LEN - 32'd1);
        mmio_narrow = (a32 >= MMIO_BASE) && (store_op_e'(op) != OP_FULL);

        flag  = misalign | !in_map | count_hit | mmio_narrow | ov;
        fault = (store_op_e'(op) != OP_NONE) && flag;
        clean = (store_op_e'(op) != OP_NONE) && !flag;
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store queue with address-error reporting; STORE_MERGE_EN enables tail merging
module store_buffer
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    input  logic                req_ov,
    output logic                exc_ades,
    output logic [ADDR_W-1:0]   exc_addr,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                empty
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [NB-1:0]     we;
        logic [DATA_W-1:0] wdata;
    } ent_t;

    ent_t              ent_q [DEPTH];
    ent_t              ent_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic              exc_ades_q, exc_ades_d;
    logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;

    logic [NB-1:0]     chk_we;
    logic [DATA_W-1:0] chk_wdata;
    logic              chk_fault;
    logic              chk_clean;
    logic [ADDR_W-1:0] aligned_addr;
    logic              full;
    logic              pop;
    logic              accept;
    logic              push;
    logic              merge_hit;
    logic [PW-1:0]     tail_idx;

    store_check #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_check (
        .op    (req_op),
        .addr  (req_addr),
        .data  (req_data),
        .ov    (req_ov),
        .we    (chk_we),
        .wdata (chk_wdata),
        .fault (chk_fault),
        .clean (chk_clean)
    );

    assign aligned_addr = {req_addr[ADDR_W-1:LB], LB'(0)};
    assign full         = (cnt_q == (PW+1)'(DEPTH));
    assign empty        = (cnt_q == '0);
    assign mem_valid    = !empty;
    assign pop          = mem_valid && mem_ready;
    assign tail_idx     = wr_ptr_q - PW'(1);

`ifdef STORE_MERGE_EN
    // A lone tail that is leaving this cycle cannot absorb the new bytes
    assign merge_hit = chk_clean && !empty && (ent_q[tail_idx].addr == aligned_addr)
                     && !(pop && (cnt_q == (PW+1)'(1)));
`else
    assign merge_hit = 1'b0;
`endif

    assign req_ready = !full || merge_hit;
    assign accept    = req_valid && req_ready;
    assign push      = accept && chk_clean && !merge_hit;

    always_comb begin
        ent_d      = ent_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        exc_ades_d = accept && chk_fault;
        exc_addr_d = (accept && chk_fault) ? req_addr : '0;
        if (push) begin
            ent_d[wr_ptr_q] = '{addr: aligned_addr, we: chk_we, wdata: chk_wdata};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (accept && merge_hit) begin
            ent_d[tail_idx].we = ent_q[tail_idx].we | chk_we;
            for (int i = 0; i < NB; i++) begin
                if (chk_we[i]) begin
                    ent_d[tail_idx].wdata[8*i +: 8] = chk_wdata[8*i +: 8];
                end
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            exc_ades_q <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            ent_q      <= ent_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            exc_ades_q <= exc_ades_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    assign exc_ades  = exc_ades_q;
    assign exc_addr  = exc_addr_q;
    assign mem_addr  = mem_valid ? ent_q[rd_ptr_q].addr  : '0;
    assign mem_we    = mem_valid ? ent_q[rd_ptr_q].we    : '0;
    assign mem_wdata = mem_valid ? ent_q[rd_ptr_q].wdata : '0;

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - table-driven and scoreboard bench for store_buffer
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_addr;
    logic [31:0] req_data;
    logic        req_ov;
    logic        exc_ades;
    logic [15:0] exc_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        empty;

    store_buffer #(.DATA_W(32), .DEPTH(4), .ADDR_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ov    (req_ov),
        .exc_ades  (exc_ades),
        .exc_addr  (exc_addr),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [31:0] data;
        logic        ov;
        logic        fault;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [15:0] maddr;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } wr_t;

    vec_t        vecs [18];
    wr_t         exp_q [$];
    logic [15:0] exc_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && mem_valid && mem_ready) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h we %0h data %0h expected none",
                         mem_addr, mem_we, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("mem_write", {12'h0, mem_addr, mem_we, mem_wdata},
                      {12'h0, e.addr, e.we, e.wdata});
            end
        end
        if (reset_n && exc_ades) begin
            if (exc_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_exc: got exc_addr %0h expected no pulse", exc_addr);
            end else begin
                check("exc_addr", 64'(exc_addr), 64'(exc_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [1:0] op, input logic [15:0] addr,
                         input logic [31:0] data, input logic ov);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        req_ov    = ov;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_ov    = 1'b0;
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 50) begin
            @(posedge clk);
            b++;
        end
        @(negedge clk);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int b;
        int w0;
        vecs[0]  = '{2'd3, 16'h0003, 32'h000000AB, 1'b0, 1'b0, 4'b1000, 32'hAB000000, 16'h0000};
        vecs[1]  = '{2'd1, 16'h0100, 32'hDEADBEEF, 1'b0, 1'b0, 4'b1111, 32'hDEADBEEF, 16'h0100};
        vecs[2]  = '{2'd2, 16'h0102, 32'h00001234, 1'b0, 1'b0, 4'b1100, 32'h12340000, 16'h0100};
        vecs[3]  = '{2'd2, 16'h0200, 32'hFFFF5678, 1'b0, 1'b0, 4'b0011, 32'h00005678, 16'h0200};
        vecs[4]  = '{2'd3, 16'h2FFF, 32'h0000005A, 1'b0, 1'b0, 4'b1000, 32'h5A000000, 16'h2FFC};
        vecs[5]  = '{2'd1, 16'h0002, 32'h11111111, 1'b0, 1'b1, 4'b0000, 32'h0,        16'h0};
        vecs[6]  = '{2'd1, 16'h7F08, 32'h22222222, 1'b0, 1'b1, 4'b0000, 32'h0,        16'h0};
        vecs[7]  = '{2'd2, 16'h0001, 32'h33333333, 1'b0, 1'b1, 4'b0000, 32'h0,        16'h0};
        vecs[8]  = '{2'd1, 16'h3000, 32'h44444444, 1'b0, 1'b1, 4'b0000, 32'h0,        16'h0};
        vecs[9]  = '{2'd1, 16'h7F00, 32'h00000001, 1'b0, 1'b0, 4'b1111, 32'h00000001, 16'h7F00};
        vecs[10] = '{2'd1, 16'h7F20, 32'hA5A5A5A5, 1'b0, 1'b0, 4'b1111, 32'hA5A5A5A5, 16'h7F20};
        vecs[11] = '{2'd3, 16'h7F01, 32'h00000077, 1'b0, 1'b1, 4'b0000, 32'h0,        16'h0};
        vecs[12] = '{2'd1, 16'h7F1C, 32'h55555555, 1'b0, 1'b1, 4'b0000, 32'h0,        16'h0};
        vecs[13] = '{2'd1, 16'h0040, 32'h66666666, 1'b1, 1'b1, 4'b0000, 32'h0,        16'h0};
        vecs[14] = '{2'd0, 16'h0002, 32'h77777777, 1'b1, 1'b0, 4'b0000, 32'h0,        16'h0};
        vecs[15] = '{2'd1, 16'h7F24, 32'h88888888, 1'b0, 1'b1, 4'b0000, 32'h0,        16'h0};
        vecs[16] = '{2'd1, 16'h7F18, 32'h99999999, 1'b0, 1'b1, 4'b0000, 32'h0,        16'h0};
        vecs[17] = '{2'd1, 16'h7F14, 32'h0BADF00D, 1'b0, 1'b0, 4'b1111, 32'h0BADF00D, 16'h7F14};

        reset_n   = 1'b0;
        mem_ready = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        idle();
        #3;
        check("rst_empty",     64'(empty),     64'd1);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_exc",       {47'h0, exc_ades, exc_addr}, 64'd0);
        check("rst_mem_bus",   {12'h0, mem_addr, mem_we, mem_wdata}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        mem_ready = 1'b1;

        for (int i = 0; i < 18; i++) begin
            logic wr;
            wr = (vecs[i].op != 2'd0) && !vecs[i].fault;
            @(posedge clk);
            #1;
            drive(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].ov);
            if (wr) exp_q.push_back('{vecs[i].maddr, vecs[i].we, vecs[i].wdata});
            if (vecs[i].fault) exc_q.push_back(vecs[i].addr);
            @(posedge clk);
            #1;
            idle();
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_mem_valid", i), 64'(mem_valid), 64'(wr));
            check($sformatf("vec%0d_latency", i), 64'(exp_q.size() + exc_q.size()), 64'd0);
        end

        // Fill with memory stalled, then release and confirm order
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(2'd1, 16'h0400 + 16'(4 * i), 32'hC0DE0000 + 32'(i), 1'b0);
            check($sformatf("fill%0d_ready", i), 64'(req_ready), 64'd1);
            exp_q.push_back('{16'h0400 + 16'(4 * i), 4'b1111, 32'hC0DE0000 + 32'(i)});
            @(posedge clk);
            #1;
        end
        drive(2'd1, 16'h0500, 32'hC0DE0004, 1'b0);
        check("full_ready_low", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("head_stable", {12'h0, mem_addr, mem_we, mem_wdata},
              {12'h0, 16'h0400, 4'b1111, 32'hC0DE0000});
        mem_ready = 1'b1;
        b = 0;
        while (!req_ready && b < 10) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("fifth_ready", 64'(req_ready), 64'd1);
        exp_q.push_back('{16'h0500, 4'b1111, 32'hC0DE0004});
        @(posedge clk);
        #1;
        idle();
        drain("fill_drain");

        // Two byte stores to the same word while memory stalls
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        drive(2'd3, 16'h0010, 32'h00000011, 1'b0);
        @(posedge clk);
        #1;
        drive(2'd3, 16'h0011, 32'h00000022, 1'b0);
        @(posedge clk);
        #1;
        idle();
`ifdef STORE_MERGE_EN
        exp_q.push_back('{16'h0010, 4'b0011, 32'h00002211});
`else
        exp_q.push_back('{16'h0010, 4'b0001, 32'h00000011});
        exp_q.push_back('{16'h0010, 4'b0010, 32'h00002200});
`endif
        check("merge_head", {12'h0, mem_addr, mem_we, mem_wdata},
              {12'h0, exp_q[0].addr, exp_q[0].we, exp_q[0].wdata});
        mem_ready = 1'b1;
        drain("merge_drain");

        // Reset with entries queued and an exception in flight
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2'd1, 16'h0800 + 16'(4 * i), 32'hFACE0000 + 32'(i), 1'b0);
            @(posedge clk);
            #1;
        end
        drive(2'd1, 16'h0802, 32'hDEAD0000, 1'b0);
        @(posedge clk);
        #1;
        idle();
        check("pre_reset_valid", 64'(mem_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_empty",     64'(empty),     64'd1);
        check("mid_rst_mem_valid", 64'(mem_valid), 64'd0);
        check("mid_rst_exc",       {47'h0, exc_ades, exc_addr}, 64'd0);
        check("mid_rst_ready",     64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        w0        = n_writes;
        repeat (10) @(posedge clk);
        #1;
        check("no_write_after_reset", 64'(n_writes - w0), 64'd0);
        check("exc_q_empty", 64'(exc_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
